// File: rtl/scope_ctrl.sv
// scope_ctrl: triggered audio oscilloscope overlay.
//   Captures 256 signed 8-bit points (sample[15:8]) into a write buffer after a
//   rising zero crossing or a free-run timeout, then swaps that buffer into the
//   display side at the next frame start. The display side renders a
//   continuous green trace, a grey centre axis and black background with
//   2 cycles of latency from pixX/pixY to rgb.
// Ports:
//   I_clk_pixel        pixel clock, all logic on its rising edge
//   I_reset            synchronous active-high reset
//   pixX / pixY        current pixel coordinate
//   screenWidth/Height active area size
//   sample, sample_valid  signed audio sample and its one-cycle strobe
//   rgb                registered pixel colour {R,G,B}
//   capturing          high while the capture FSM is in CAPTURE
//   swapped            one-cycle pulse when write/display buffers swap
module scope_ctrl #(
  parameter int VIDEO_X_BITWIDTH = 12,
  parameter int VIDEO_Y_BITWIDTH = 12,
  parameter int XSHIFT           = 2,
  parameter int TRIG_TIMEOUT     = 1024
) (
  input  logic                        I_clk_pixel,
  input  logic                        I_reset,
  input  logic [VIDEO_X_BITWIDTH-1:0] pixX,
  input  logic [VIDEO_Y_BITWIDTH-1:0] pixY,
  input  logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
  input  logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
  input  logic [15:0]                 sample,
  input  logic                        sample_valid,
  output logic [23:0]                 rgb,
  output logic                        capturing,
  output logic                        swapped
);

  localparam int XW = VIDEO_X_BITWIDTH;
  localparam int YW = VIDEO_Y_BITWIDTH;
  localparam int SW = YW + 1;
  localparam int TW = $clog2(TRIG_TIMEOUT + 1);

  localparam logic [23:0] COL_TRACE = 24'h00FF00;
  localparam logic [23:0] COL_AXIS  = 24'h404040;
  localparam logic [23:0] COL_BG    = 24'h000000;

  typedef enum logic [1:0] {ARMED, CAPTURE, FULL} state_e;

  // ---------------------------------------------------------------------------
  // Capture side
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          prev_neg_q, prev_neg_d;
  logic          rd_sel_q, rd_sel_d;
  logic          swapped_q, swapped_d;

  logic          frame_start;
  logic          cur_neg;
  logic          crossing;
  logic          timeout;
  logic          trigger;
  logic          wr_en;
  logic          do_swap;
  logic [7:0]    wr_addr;

  logic [7:0]    buf0_mem [256];
  logic [7:0]    buf1_mem [256];

  always_comb begin
    frame_start = (pixX == '0) && (pixY == '0);
    cur_neg     = $signed(sample) < 16'sd0;
    crossing    = prev_neg_q && !cur_neg;
    timeout     = tmo_q == TW'(TRIG_TIMEOUT - 1);
    trigger     = sample_valid && (crossing || timeout);
  end

  // State register
  always_ff @(posedge I_clk_pixel) begin
    if (I_reset) state_q <= ARMED;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:   if (trigger) state_d = CAPTURE;
      CAPTURE: if (sample_valid && (wr_idx_q == 8'hFF)) state_d = FULL;
      FULL:    if (frame_start) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_en     = 1'b0;
    do_swap   = 1'b0;
    capturing = 1'b0;
    case (state_q)
      ARMED:   wr_en = trigger;
      CAPTURE: begin
        wr_en     = sample_valid;
        capturing = 1'b1;
      end
      FULL:    do_swap = frame_start;
      default: ;
    endcase
  end

  // The triggering sample always lands at index 0, so ARMED writes address 0
  // and the index register is preloaded with 1 for the next CAPTURE write.
  always_comb begin
    wr_addr    = (state_q == ARMED) ? 8'd0 : wr_idx_q;
    wr_idx_d   = wr_idx_q;
    tmo_d      = tmo_q;
    prev_neg_d = prev_neg_q;
    rd_sel_d   = rd_sel_q;
    swapped_d  = do_swap;
    if (wr_en) wr_idx_d = wr_addr + 8'd1;
    if ((state_q == ARMED) && sample_valid) begin
      tmo_d = trigger ? '0 : tmo_q + TW'(1);
    end
    if (do_swap) begin
      rd_sel_d = ~rd_sel_q;
      tmo_d    = '0;
    end
    if (sample_valid && (state_q != FULL)) prev_neg_d = cur_neg;
  end

  always_ff @(posedge I_clk_pixel) begin
    if (I_reset) begin
      wr_idx_q   <= '0;
      tmo_q      <= '0;
      prev_neg_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      swapped_q  <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      tmo_q      <= tmo_d;
      prev_neg_q <= prev_neg_d;
      rd_sel_q   <= rd_sel_d;
      swapped_q  <= swapped_d;
    end
  end

  assign swapped = swapped_q;

  // The write buffer is always the one not being displayed. Writes and swaps
  // never coincide (writes only in ARMED/CAPTURE, swaps only in FULL).
  always_ff @(posedge I_clk_pixel) begin
    if (wr_en && !I_reset) begin
      if (rd_sel_q) buf0_mem[wr_addr] <= sample[15:8];
      else          buf1_mem[wr_addr] <= sample[15:8];
    end
  end

  // ---------------------------------------------------------------------------
  // Display side, stage 0: column decode and synchronous buffer read
  // ---------------------------------------------------------------------------
  logic [XW-1:0] col;
  logic [7:0]    rd_addr;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          trace_en;
  logic          width_en;

  logic [YW-1:0] y_p1_q;
  logic [XW-1:0] col_p1_q;
  logic          trace_en_p1_q;
  logic          width_en_p1_q;

  always_comb begin
    col      = pixX >> XSHIFT;
    rd_addr  = col[7:0];
    width_en = pixX < screenWidth;
    trace_en = width_en && (col < XW'(256));
    // rd_sel_d rather than rd_sel_q so the frame-start pixel itself already
    // reads from the newly swapped buffer.
    rd_data_d = rd_sel_d ? buf1_mem[rd_addr] : buf0_mem[rd_addr];
  end

  always_ff @(posedge I_clk_pixel) begin
    rd_data_q <= rd_data_d;
  end

  always_ff @(posedge I_clk_pixel) begin
    if (I_reset) begin
      y_p1_q        <= '0;
      col_p1_q      <= '0;
      trace_en_p1_q <= 1'b0;
      width_en_p1_q <= 1'b0;
    end else begin
      y_p1_q        <= pixY;
      col_p1_q      <= col;
      trace_en_p1_q <= trace_en;
      width_en_p1_q <= width_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Display side, stage 1: trace row, line fill, colour select
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] half_s, v_ext, t_now, y_s;
  logic signed [SW-1:0] t_left, t_lo, t_hi;
  logic signed [SW-1:0] t_hold_q, t_hold_d, t_prev_q, t_prev_d;
  logic [XW-1:0]        col_hold_q, col_hold_d;
  logic                 col_chg;
  logic                 hit;
  logic                 lit;
  logic                 axis;
  logic [23:0]          rgb_q, rgb_d;

  // t_hold is the current column's trace row, t_prev the previous column's.
  // On the first pixel of a new column the registers have not shifted yet,
  // so the left neighbour is still sitting in t_hold.
  always_comb begin
    half_s     = SW'(screenHeight >> 1);
    v_ext      = {{(SW-8){rd_data_q[7]}}, rd_data_q};
    t_now      = half_s - v_ext;
    y_s        = SW'(y_p1_q);
    col_chg    = col_p1_q != col_hold_q;
    t_left     = col_chg ? t_hold_q : t_prev_q;
    t_lo       = (t_left < t_now) ? t_left : t_now;
    t_hi       = (t_left < t_now) ? t_now : t_left;
    col_hold_d = col_hold_q;
    t_hold_d   = t_hold_q;
    t_prev_d   = t_prev_q;
    if (col_chg) begin
      col_hold_d = col_p1_q;
      t_hold_d   = t_now;
      t_prev_d   = t_hold_q;
    end
    if (col_p1_q == '0) hit = (y_s == t_now);
    else                hit = (y_s >= t_lo) && (y_s <= t_hi);
    lit  = trace_en_p1_q && hit;
    // The axis spans the whole active width, including columns past the
    // 256-point trace.
    axis = width_en_p1_q && (y_p1_q == (screenHeight >> 1));
    if (lit)       rgb_d = COL_TRACE;
    else if (axis) rgb_d = COL_AXIS;
    else           rgb_d = COL_BG;
  end

  always_ff @(posedge I_clk_pixel) begin
    if (I_reset) begin
      col_hold_q <= '0;
      t_hold_q   <= '0;
      t_prev_q   <= '0;
      rgb_q      <= '0;
    end else begin
      col_hold_q <= col_hold_d;
      t_hold_q   <= t_hold_d;
      t_prev_q   <= t_prev_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_scope_ctrl.sv
module tb_scope_ctrl;

  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] GREY  = 24'h404040;
  localparam logic [23:0] BLACK = 24'h000000;

  logic        clk = 1'b0;
  logic        I_reset;
  logic [11:0] pixX, pixY;
  logic [11:0] screenWidth  = 12'd1280;
  logic [11:0] screenHeight = 12'd480;
  logic [15:0] sample;
  logic        sample_valid;
  logic [23:0] rgb;
  logic        capturing;
  logic        swapped;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] rgb;
    int          x;
    int          y;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic       chk_en = 1'b0;
  logic [1:0] vpipe  = '0;

  always #5 clk = ~clk;

  scope_ctrl #(
    .VIDEO_X_BITWIDTH(12),
    .VIDEO_Y_BITWIDTH(12),
    .XSHIFT(2),
    .TRIG_TIMEOUT(1024)
  ) dut (
    .I_clk_pixel (clk),
    .I_reset     (I_reset),
    .pixX        (pixX),
    .pixY        (pixY),
    .screenWidth (screenWidth),
    .screenHeight(screenHeight),
    .sample      (sample),
    .sample_valid(sample_valid),
    .rgb         (rgb),
    .capturing   (capturing),
    .swapped     (swapped)
  );

  // Monitor: a pixel flagged for checking shows up on rgb two edges later.
  always @(posedge clk) vpipe <= {vpipe[0], chk_en};

  always @(negedge clk) begin
    if (vpipe[1]) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL pix_underflow: rgb=%06h with no expected entry", rgb);
      end else begin
        mon_e = sb_q.pop_front();
        if (rgb !== mon_e.rgb) begin
          errors++;
          $display("FAIL pix(%0d,%0d): rgb got %06h expected %06h",
                   mon_e.x, mon_e.y, rgb, mon_e.rgb);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input bit en, input logic [23:0] exp);
    @(posedge clk); #1;
    pixX   = 12'(x);
    pixY   = 12'(y);
    chk_en = en;
    if (en) sb_q.push_back('{rgb: exp, x: x, y: y});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pixX   = '1;
    pixY   = '1;
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Scan row y from x=0 so the left-neighbour register is filled in order;
  // check the first and last pixel of column c.
  task automatic row_chk(input int y, input int c, input logic [23:0] exp);
    for (int x = 0; x <= c * 4 + 3; x++) pix(x, y, (x == c * 4) || (x == c * 4 + 3), exp);
    idle();
  endtask

  task automatic send(input logic [15:0] s);
    @(posedge clk); #1;
    sample       = s;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic frame_start(input string name, input logic exp_sw);
    @(posedge clk); #1;
    pixX = '0;
    pixY = '0;
    @(posedge clk); #1;
    pixX = '1;
    pixY = '1;
    check(name, swapped, exp_sw);
    @(posedge clk); #1;
    check({name, "_after"}, swapped, 1'b0);
  endtask

  function automatic logic [15:0] sine(input int i);
    real r;
    r = 16384.0 * $sin(6.283185307179586 * real'(i) / 64.0);
    return 16'($rtoi(r));
  endfunction

  initial begin
    I_reset      = 1'b1;
    pixX         = '1;
    pixY         = '1;
    sample       = '0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", rgb, 24'h0);
    check("reset_capturing", capturing, 1'b0);
    check("reset_swapped", swapped, 1'b0);
    I_reset = 1'b0;

    // Timeout trigger: constant positive level, no crossing.
    for (int i = 0; i < 500; i++) send(16'h1000);
    frame_start("armed_no_swap", 1'b0);
    for (int i = 0; i < 523; i++) send(16'h1000);
    check("tmo_1023_idle", capturing, 1'b0);
    send(16'h1000);
    check("tmo_1024_capture", capturing, 1'b1);
    for (int i = 0; i < 254; i++) send(16'h1000);
    check("tmo_idx254_capture", capturing, 1'b1);
    send(16'h1000);
    check("tmo_full", capturing, 1'b0);
    send(16'h1000);
    check("full_ignores_valid", capturing, 1'b0);
    check("full_no_swap_yet", swapped, 1'b0);
    frame_start("tmo_swap", 1'b1);
    // all entries 0x10 -> trace row 240-16 = 224
    row_chk(224, 0, GREEN);
    row_chk(240, 0, GREY);
    row_chk(224, 5, GREEN);
    row_chk(223, 5, BLACK);

    // Sine capture, frame start mid-capture must not swap.
    send(sine(-1));
    for (int i = 0; i < 128; i++) send(sine(i));
    check("sine_capturing", capturing, 1'b1);
    frame_start("capture_no_swap", 1'b0);
    for (int i = 128; i < 256; i++) send(sine(i));
    check("sine_full", capturing, 1'b0);
    // still showing the constant capture
    row_chk(224, 0, GREEN);
    row_chk(240, 0, GREY);
    frame_start("sine_swap", 1'b1);
    row_chk(240, 0, GREEN);
    row_chk(239, 0, BLACK);
    row_chk(241, 0, BLACK);
    // col15 entry 63 -> 177, col16 entry 64 -> 176
    row_chk(176, 16, GREEN);
    row_chk(177, 16, GREEN);
    row_chk(175, 16, BLACK);
    row_chk(178, 16, BLACK);
    // col7 entry 40 -> 200, col8 entry 45 -> 195
    row_chk(198, 8, GREEN);
    row_chk(194, 8, BLACK);
    row_chk(201, 8, BLACK);

    // Step: entry 10 = 0x40, all others 0.
    send(16'hFF00);
    for (int i = 0; i < 256; i++) send((i == 10) ? 16'h4000 : 16'h0000);
    check("step_full", capturing, 1'b0);
    frame_start("step_swap", 1'b1);
    row_chk(176, 10, GREEN);
    row_chk(200, 10, GREEN);
    row_chk(240, 10, GREEN);
    row_chk(175, 10, BLACK);
    row_chk(241, 10, BLACK);
    row_chk(200, 11, GREEN);
    row_chk(200, 9, BLACK);
    row_chk(240, 9, GREEN);

    // Reset at write index 100.
    send(16'hFF00);
    send(16'h0000);
    for (int i = 1; i < 100; i++) send(16'h2000);
    check("partial_capturing", capturing, 1'b1);
    @(posedge clk); #1;
    I_reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_rgb", rgb, 24'h0);
    check("midrst_capturing", capturing, 1'b0);
    check("midrst_swapped", swapped, 1'b0);
    I_reset = 1'b0;
    // display back on buffer 0, which holds the partial 0x20 data (row 208)
    row_chk(208, 5, GREEN);
    send(16'hFF00);
    send(16'h0000);
    for (int i = 1; i < 255; i++) send(16'hE000);
    check("fresh_idx254_capturing", capturing, 1'b1);
    frame_start("fresh_incomplete_no_swap", 1'b0);
    send(16'hE000);
    check("fresh_full", capturing, 1'b0);
    frame_start("fresh_swap", 1'b1);
    row_chk(272, 5, GREEN);
    row_chk(240, 0, GREEN);

    // Column 256: axis only, no trace.
    pix(1024, 240, 1'b1, GREY);
    pix(1024, 272, 1'b1, BLACK);
    idle();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
